// File: rtl/sccb_pkg.sv
// Shared types and constants for the OV7670 SCCB write master.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_STOP  = 3'd3,
    ST_WAIT  = 3'd4
  } sccb_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } sccb_req_t;

  localparam logic [7:0] OV7670_WR_ID = 8'h42;
  localparam logic [7:0] COM7_ADDR    = 8'h12;

  // Clocks per quarter SIOC period, truncated, never below one.
  function automatic int unsigned calc_qdiv(input int unsigned clk_freq,
                                            input int unsigned sccb_freq);
    int unsigned q;
    q = clk_freq / (4 * sccb_freq);
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/sccb_master_if.sv
// Request/busy handshake from the init sequencer plus the SIOC/SIOD pins.
interface sccb_master_if;
  logic       sccb_start;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_busy;
  logic       sioc;
  logic       siod_o;
  logic       siod_oe;
  logic       siod_i;
  logic       nack;

  modport master (
    input  sccb_start, sccb_addr, sccb_data, siod_i,
    output sccb_busy, sioc, siod_o, siod_oe, nack
  );

  modport slave (
    output sccb_start, sccb_addr, sccb_data, siod_i,
    input  sccb_busy, sioc, siod_o, siod_oe, nack
  );
endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-period tick divider; one tick every QDIV clocks, held at zero by i_clr.
module sccb_tick_gen #(
  parameter int unsigned QDIV = 62
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  output logic o_tick_c
);
  localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        r_cnt <= '0;
    else if (i_clr || r_cnt == LAST)  r_cnt <= '0;
    else                              r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick_c = !i_clr && (r_cnt == LAST);
endmodule

// File: rtl/sccb_master.sv
// SCCB 3-phase write master: serialises {ID, addr, data} onto SIOC/SIOD and
// holds busy through the bus-free (or COM7 soft-reset) hold-off.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 25000000,
  parameter int unsigned SCCB_FREQ       = 100000,
  parameter logic [7:0]  DEV_ADDR        = OV7670_WR_ID,
  parameter int unsigned TBUF_CYCLES     = 64,
  parameter int unsigned RST_WAIT_CYCLES = 25000
) (
  input  logic           clk,
  input  logic           rstn,
  sccb_master_if.master  bus
);
  localparam int unsigned QDIV = calc_qdiv(CLK_FREQ, SCCB_FREQ);
  localparam int unsigned WMAX = (TBUF_CYCLES > RST_WAIT_CYCLES) ? TBUF_CYCLES : RST_WAIT_CYCLES;
  localparam int unsigned WW   = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam logic [WW-1:0] TBUF_LAST = WW'(TBUF_CYCLES - 1);
  localparam logic [WW-1:0] RST_LAST  = WW'(RST_WAIT_CYCLES - 1);

  sccb_state_e   r_state, w_state_nxt;
  logic [1:0]    r_q, w_q_nxt;
  logic [1:0]    r_phase, w_phase_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [WW-1:0] r_wcnt, w_wcnt_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_nack, w_nack_nxt;
  sccb_req_t     r_req, w_req_nxt;
  logic          r_sioc, r_siod_o, r_siod_oe;
  logic          w_sioc_nxt, w_siod_nxt, w_oe_nxt;
  logic          w_tick, w_accept;
  logic [WW-1:0] w_wait_last;
  logic [7:0]    w_byte;
  logic [2:0]    w_bit_idx;

  sccb_tick_gen #(.QDIV(QDIV)) u_tick (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   ((r_state == ST_IDLE) || (r_state == ST_WAIT)),
    .o_tick_c(w_tick)
  );

  assign w_accept    = bus.sccb_start && (r_state == ST_IDLE);
  assign w_wait_last = ((r_req.addr == COM7_ADDR) && r_req.data[7]) ? RST_LAST : TBUF_LAST;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_q       <= '0;
      r_phase   <= '0;
      r_bit     <= '0;
      r_wcnt    <= '0;
      r_busy    <= 1'b0;
      r_nack    <= 1'b0;
      r_req     <= '0;
      r_sioc    <= 1'b1;
      r_siod_o  <= 1'b1;
      r_siod_oe <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_q       <= w_q_nxt;
      r_phase   <= w_phase_nxt;
      r_bit     <= w_bit_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_busy    <= w_busy_nxt;
      r_nack    <= w_nack_nxt;
      r_req     <= w_req_nxt;
      r_sioc    <= w_sioc_nxt;
      r_siod_o  <= w_siod_nxt;
      r_siod_oe <= w_oe_nxt;
    end
  end

  // Sequencing: each state runs four quarters; BIT repeats 9 bits x 3 phases.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_wcnt_nxt  = r_wcnt;
    w_busy_nxt  = r_busy;
    w_nack_nxt  = r_nack;
    w_req_nxt   = r_req;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_state_nxt = ST_START;
        w_q_nxt     = '0;
        w_phase_nxt = '0;
        w_bit_nxt   = '0;
        w_busy_nxt  = 1'b1;
        w_nack_nxt  = 1'b0;
        w_req_nxt   = '{addr: bus.sccb_addr, data: bus.sccb_data};
      end
      ST_START: if (w_tick) begin
        w_q_nxt = r_q + 2'd1;
        if (r_q == 2'd3) w_state_nxt = ST_BIT;
      end
      ST_BIT: if (w_tick) begin
        if (r_q == 2'd2 && r_bit == 4'd8 && bus.siod_i) w_nack_nxt = 1'b1;
        w_q_nxt = r_q + 2'd1;
        if (r_q == 2'd3) begin
          if (r_bit == 4'd8) begin
            w_bit_nxt = '0;
            if (r_phase == 2'd2) begin
              w_phase_nxt = '0;
              w_state_nxt = ST_STOP;
            end else begin
              w_phase_nxt = r_phase + 2'd1;
            end
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
      ST_STOP: if (w_tick) begin
        w_q_nxt = r_q + 2'd1;
        if (r_q == 2'd3) begin
          w_state_nxt = ST_WAIT;
          w_wcnt_nxt  = '0;
        end
      end
      ST_WAIT: begin
        if (r_wcnt == w_wait_last) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_wcnt_nxt  = '0;
        end else begin
          w_wcnt_nxt = r_wcnt + WW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_bit_idx = 3'(4'd7 - w_bit_nxt);
  assign w_byte    = (w_phase_nxt == 2'd0) ? DEV_ADDR :
                     (w_phase_nxt == 2'd1) ? w_req_nxt.addr : w_req_nxt.data;

  // Pin levels for the quarter being entered, registered with the state.
  always_comb begin
    w_sioc_nxt = 1'b1;
    w_siod_nxt = 1'b1;
    w_oe_nxt   = 1'b1;
    case (w_state_nxt)
      ST_START: begin
        w_sioc_nxt = (w_q_nxt < 2'd2);
        w_siod_nxt = (w_q_nxt == 2'd0);
      end
      ST_BIT: begin
        w_sioc_nxt = (w_q_nxt == 2'd1) || (w_q_nxt == 2'd2);
        if (w_bit_nxt == 4'd8) w_oe_nxt   = 1'b0;
        else                   w_siod_nxt = w_byte[w_bit_idx];
      end
      ST_STOP: begin
        w_sioc_nxt = (w_q_nxt != 2'd0);
        w_siod_nxt = (w_q_nxt >= 2'd2);
      end
      default: ;
    endcase
  end

  assign bus.sccb_busy = r_busy || w_accept;
  assign bus.sioc      = r_sioc;
  assign bus.siod_o    = r_siod_o;
  assign bus.siod_oe   = r_siod_oe;
  assign bus.nack      = r_nack;
endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master: decodes SIOC/SIOD, models camera ACKs,
// and checks busy timing, nack, reset and ignored starts.
module tb_sccb_master;
  logic clk = 1'b0;
  logic rstn;
  logic cam_release;
  int   n_rise;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sccb_master_if bus();

  // Camera pulls ACK low; with cam_release set it lets the bus float high in phase 2.
  assign bus.siod_i = bus.siod_oe ? bus.siod_o : ((cam_release && n_rise >= 19) ? 1'b1 : 1'b0);

  sccb_master #(
    .CLK_FREQ(25000000), .SCCB_FREQ(100000), .DEV_ADDR(8'h42),
    .TBUF_CYCLES(64), .RST_WAIT_CYCLES(25000)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.master)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         release_ack;
    bit         poke;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    logic [7:0] exp_b2;
    bit         exp_nack;
    int         exp_busy;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_xfer(input vec_t v);
    logic [26:0] bits;
    logic        p_sioc, p_siod;
    int          oe_bad, glitches, busy_cnt, cyc, diff;
    bit          done;
    bits = '0; oe_bad = 0; glitches = 0; done = 0; cyc = 0;
    @(negedge clk);
    bus.sccb_addr  = v.addr;
    bus.sccb_data  = v.data;
    bus.sccb_start = 1'b1;
    cam_release    = v.release_ack;
    n_rise         = 0;
    #1 check("busy_same_cycle", int'(bus.sccb_busy), 1);
    busy_cnt = 1;
    p_sioc = bus.sioc;
    p_siod = bus.siod_o;
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      bus.sccb_start = v.poke && (cyc == 100);
      if (v.poke && cyc == 100) begin
        bus.sccb_addr = 8'hFF;
        bus.sccb_data = 8'hFF;
      end
      if (!bus.sccb_busy) begin
        done = 1;
      end else begin
        busy_cnt++;
        if (bus.sioc && !p_sioc) begin
          if (n_rise < 27) begin
            bits[26-n_rise] = bus.siod_i;
            if (((n_rise % 9) == 8) == bus.siod_oe) oe_bad++;
          end
          n_rise++;
        end
        if (bus.sioc && p_sioc && (bus.siod_o != p_siod)) glitches++;
        p_sioc = bus.sioc;
        p_siod = bus.siod_o;
      end
    end
    bus.sccb_start = 1'b0;
    check("busy_drop_in_budget", int'(done), 1);
    check("byte_id",   int'(bits[26:19]), int'(v.exp_b0));
    check("byte_addr", int'(bits[17:10]), int'(v.exp_b1));
    check("byte_data", int'(bits[8:1]),   int'(v.exp_b2));
    check("ack_slot_oe_errors", oe_bad, 0);
    check("sioc_rises", n_rise, 28);
    check("siod_edges_while_sioc_high", glitches, 2);
    check("nack", int'(bus.nack), int'(v.exp_nack));
    check("idle_pins", int'({bus.sioc, bus.siod_o, bus.siod_oe}), 7);
    n_chk++;
    diff = busy_cnt - v.exp_busy;
    if (diff >= -1 && diff <= 1) n_pass++;
    else $display("FAIL busy_len: got %0d expected %0d +-1", busy_cnt, v.exp_busy);
  endtask

  initial begin
    logic p_sioc;
    int   cyc;
    vecs[0] = '{8'h3A, 8'h04, 1'b0, 1'b1, 8'h42, 8'h3A, 8'h04, 1'b0, 116*62 + 64};
    vecs[1] = '{8'h12, 8'h80, 1'b0, 1'b0, 8'h42, 8'h12, 8'h80, 1'b0, 116*62 + 25000};
    vecs[2] = '{8'h12, 8'h04, 1'b1, 1'b0, 8'h42, 8'h12, 8'h04, 1'b1, 116*62 + 64};
    vecs[3] = '{8'h6B, 8'hC5, 1'b0, 1'b0, 8'h42, 8'h6B, 8'hC5, 1'b0, 116*62 + 64};

    rstn = 1'b0;
    bus.sccb_start = 1'b0;
    bus.sccb_addr  = 8'h00;
    bus.sccb_data  = 8'h00;
    cam_release    = 1'b0;
    n_rise         = 0;
    repeat (3) @(negedge clk);
    check("rst_sioc",    int'(bus.sioc), 1);
    check("rst_siod_o",  int'(bus.siod_o), 1);
    check("rst_siod_oe", int'(bus.siod_oe), 1);
    check("rst_nack",    int'(bus.nack), 0);
    check("rst_busy",    int'(bus.sccb_busy), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) run_xfer(vecs[i]);

    // Accept clears a stale nack; then reset lands at phase 1 bit 3.
    @(negedge clk);
    bus.sccb_addr = 8'h55; bus.sccb_data = 8'hAA; bus.sccb_start = 1'b1;
    cam_release = 1'b0; n_rise = 0;
    @(negedge clk);
    bus.sccb_start = 1'b0;
    check("nack_cleared_on_accept", int'(bus.nack), 0);
    p_sioc = bus.sioc;
    cyc = 0;
    while (n_rise < 13 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus.sioc && !p_sioc) n_rise++;
      p_sioc = bus.sioc;
    end
    check("reached_phase1_bit3", n_rise, 13);
    check("busy_before_reset", int'(bus.sccb_busy), 1);
    rstn = 1'b0;
    #1;
    check("async_rst_pins", int'({bus.sioc, bus.siod_o, bus.siod_oe}), 7);
    check("async_rst_busy", int'(bus.sccb_busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(vecs[3]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sccb_master.md
Name: sccb_master

Overview:
- SCCB 3-phase write master for the OV7670 camera.
- Sits directly downstream of the camera register-init sequencer. It accepts one {register address, data} pair per sccb_start pulse and serialises device-ID, address and data onto SIOC/SIOD.
- Holds sccb_busy high until the bus is free again, which paces the sequencer through its register table.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- SCCB_FREQ, 100000, SIOC frequency in Hz.
- DEV_ADDR, 8'h42, OV7670 write ID (phase 1 byte).
- TBUF_CYCLES, 64, idle clk cycles after STOP before busy drops.
- RST_WAIT_CYCLES, 25000, extra hold-off after a COM7 soft-reset write (1 ms at 25 MHz).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- sccb_start  in  1  one-cycle request; sampled only when not busy.
- sccb_addr  in  8  register address; captured with start.
- sccb_data  in  8  register data; captured with start.
- sccb_busy  out  1  transfer in progress.
- sioc  out  1  SCCB clock.
- siod_o  out  1  SIOD drive value.
- siod_oe  out  1  SIOD output enable; the top level builds the tristate.
- nack  out  1  set if any ACK slot read high during the last transfer.

Behaviour:
- Clocking and reset:
  - Single clock clk; reset asynchronous, active-low on rstn.
  - Reset values: sioc=1, siod_o=1, siod_oe=1, nack=0, internal busy=0, state=IDLE, all counters 0.
- Quarter-tick divider:
  - QDIV = CLK_FREQ/(4*SCCB_FREQ), integer truncation, minimum 1.
  - One tick every QDIV clks.
  - The divider is held at 0 in IDLE and restarts on accept.
- sccb_busy = busy_reg OR (sccb_start AND state==IDLE).
  - This is combinational so busy is already high in the cycle start is presented.
  - busy_reg sets on the accepting edge.
- Start handling:
  - Accept happens when sccb_start=1 and state==IDLE: latch addr/data, clear nack, go to START.
  - Start while busy_reg=1 is ignored; latched values are unchanged.
- States:
  - IDLE: sioc=1, siod_o=1, siod_oe=1.
  - START: q0 SIOD=1, SIOC=1; q1 SIOD=0; q2 SIOC=0; q3 hold; then BIT.
  - BIT:
    - 3 phases x 9 bits; phase counter 0..2, bit counter 0..8.
    - Byte per phase: DEV_ADDR, addr, data; MSB first.
    - Per bit: q0 SIOC=0 and update SIOD; q1 SIOC=1; q2 SIOC=1; q3 SIOC=0.
    - Bit 8 is the don't-care/ACK slot: siod_oe=0, and SIOD is sampled at end of q2. A 1 sets nack.
    - After phase 2 bit 8, go to STOP.
  - STOP: q0 SIOC=0, SIOD=0, oe=1; q1 SIOC=1; q2 SIOD=1; q3 hold; then WAIT.
  - WAIT:
    - Count TBUF_CYCLES clks. Count RST_WAIT_CYCLES instead if the latched addr==8'h12 and data[7]==1.
    - Then clear busy_reg and go to IDLE.
- Transfer length: 4+108+4 quarter ticks, then WAIT.
- Timing rule: SIOD changes only while SIOC is low, except the START and STOP edges.
- Counter widths are sized with $clog2 of QDIV and of max(TBUF_CYCLES, RST_WAIT_CYCLES); no wrap is possible within a transfer.
- Reset mid-transfer: outputs return to idle values immediately and asynchronously. No STOP is generated; the camera recovers on the next START.
- nack is held until the next accept; it is informational only.

Decomposition:
- Package sccb_pkg:
  - state encoding (IDLE, START, BIT, STOP, WAIT);
  - OV7670_WR_ID=8'h42;
  - COM7_ADDR=8'h12;
  - a QDIV computation function.
- Sub-module sccb_tick_gen: parameterised quarter-period tick divider with synchronous clear.
- Everything else stays in sccb_master.

Test Plan:
- Single write, CLK_FREQ 25 MHz, SCCB 100 kHz (QDIV=62), start with addr=8'h3A, data=8'h04:
  - bit-banged decode on SIOC rising edges yields 0x42, 0x3A, 0x04;
  - siod_oe=0 during the three ACK slots;
  - busy stays high for (116*62 + 64) clks ± 1.
- Same-cycle busy: sampling sccb_busy in the cycle sccb_start=1 returns 1; a registered sequencer advances exactly once per write.
- Start ignored while busy: second start at cycle 100 with addr=8'hFF produces no change to the captured bytes; exactly one transfer occurs.
- COM7 reset write addr=8'h12, data=8'h80: busy is extended by 25000 clks after STOP. With data=8'h04, the extension is only 64 clks.
- ACK sampling:
  - camera model pulls SIOD low in all ACK slots: nack=0;
  - SIOD released (pulled high) in phase 2: nack=1, cleared on the next accept.
- Reset asserted at phase 1 bit 3: sioc=1, siod_o=1, siod_oe=1, busy=0 asynchronously. The next start produces a full, correct transfer.
